// File: rtl/seq_detector_if.sv
// Control and result signals of the serial pattern detector.
// The master drives samples and controls; the slave is the detector.
interface seq_detector_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
  logic             inp_valid;
  logic             inp;
  logic             clear_cnt;
  logic             outp;
  logic [CNT_W-1:0] match_count;
  logic             cnt_sat;
  logic [1:0]       state;

  modport master (
    output enable,
    output load,
    output pattern_in,
    output inp_valid,
    output inp,
    output clear_cnt,
    input  outp,
    input  match_count,
    input  cnt_sat,
    input  state
  );

  modport slave (
    input  enable,
    input  load,
    input  pattern_in,
    input  inp_valid,
    input  inp,
    input  clear_cnt,
    output outp,
    output match_count,
    output cnt_sat,
    output state
  );
endinterface

// File: rtl/seq_detector.sv
// Serial pattern detector: compares the last PAT_W accepted bits against a loadable
// pattern, emits a registered match pulse and keeps a saturating match count.
module seq_detector #(
  parameter int unsigned      PAT_W     = 4,
  parameter int unsigned      OVERLAP   = 1,
  parameter int unsigned      CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011)
) (
  input logic           clock,
  input logic           reset_n,
  seq_detector_if.slave bus
);

  localparam int unsigned      FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFill  = 2'b01,
    StArmed = 2'b10
  } state_e;

  logic [PAT_W-2:0] hist_q;
  logic [FillW-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pattern_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q;
  logic             outp_q;
  state_e           state_q;

  logic             load_en;
  logic             accept;
  logic             match;
  logic             state_ok;
  logic [PAT_W-1:0] window;

  // Loads are ignored while disabled so the pattern holds with the rest of the state.
  assign load_en  = bus.enable & bus.load;
  assign accept   = bus.enable & bus.inp_valid & ~bus.load;
  assign window   = {hist_q, bus.inp};
  assign match    = accept && (fill_q >= FillLast) && (window == pattern_q);
  assign state_ok = (state_q == StIdle) || (state_q == StFill) || (state_q == StArmed);

  always_comb begin
    fill_d = fill_q;
    if (load_en) begin
      fill_d = '0;
    end else if (accept) begin
      if (match && (OVERLAP == 0)) begin
        fill_d = '0;
      end else if (fill_q != FillFull) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  // A clear coinciding with a match restarts the count at one.
  always_comb begin
    count_d = count_q;
    if (bus.clear_cnt) begin
      count_d = match ? CNT_W'(1) : '0;
    end else if (match && (count_q != CntMax)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RESET_PAT;
      count_q   <= '0;
      sat_q     <= 1'b0;
      outp_q    <= 1'b0;
      state_q   <= StIdle;
    end else begin
      if (load_en) begin
        pattern_q <= bus.pattern_in;
        hist_q    <= '0;
      end else if (accept) begin
        hist_q <= window[PAT_W-2:0];
      end
      fill_q  <= fill_d;
      outp_q  <= match & state_ok;
      count_q <= count_d;
      sat_q   <= (sat_q & ~bus.clear_cnt) | (count_d == CntMax);

      if (!bus.enable) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle:  state_q <= (fill_d == FillFull) ? StArmed : StFill;
          StFill:  if (fill_d == FillFull) state_q <= StArmed;
          StArmed: if (load_en || (match && (OVERLAP == 0))) state_q <= StFill;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.outp        = outp_q;
  assign bus.match_count = count_q;
  assign bus.cnt_sat     = sat_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: an overlapping and a non-overlapping detector share one
// stimulus stream; expected pulses are queued at drive time and checked after each edge.
module tb_seq_detector;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  seq_detector_if #(.PAT_W(4), .CNT_W(8)) bus_ov ();
  seq_detector_if #(.PAT_W(4), .CNT_W(8)) bus_no ();

  seq_detector #(
    .PAT_W    (4),
    .OVERLAP  (1),
    .CNT_W    (8),
    .RESET_PAT(4'b1011)
  ) dut_ov (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_ov)
  );

  seq_detector #(
    .PAT_W    (4),
    .OVERLAP  (0),
    .CNT_W    (8),
    .RESET_PAT(4'b1011)
  ) dut_no (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_no)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_e;

  task automatic check_value(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic set_inputs(input logic en, input logic ld, input logic [3:0] pat,
                            input logic v, input logic b, input logic clr);
    bus_ov.enable = en; bus_ov.load = ld; bus_ov.pattern_in = pat;
    bus_ov.inp_valid = v; bus_ov.inp = b; bus_ov.clear_cnt = clr;
    bus_no.enable = en; bus_no.load = ld; bus_no.pattern_in = pat;
    bus_no.inp_valid = v; bus_no.inp = b; bus_no.clear_cnt = clr;
  endtask

  // Expected outp of both detectors for the cycle after this drive.
  task automatic drive(input logic en, input logic ld, input logic [3:0] pat, input logic v,
                       input logic b, input logic clr, input logic e_ov, input logic e_no);
    @(negedge clock);
    set_inputs(en, ld, pat, v, b, clr);
    exp_q.push_back({e_ov, e_no});
  endtask

  task automatic sample(input logic b, input logic e_ov, input logic e_no);
    drive(1'b1, 1'b0, 4'h0, 1'b1, b, 1'b0, e_ov, e_no);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic check_counts(input string tag, input int unsigned c_ov, input int unsigned c_no,
                              input int unsigned s_ov, input int unsigned s_no);
    check_value({tag, "_cnt_ov"}, bus_ov.match_count, c_ov);
    check_value({tag, "_cnt_no"}, bus_no.match_count, c_no);
    check_value({tag, "_sat_ov"}, bus_ov.cnt_sat, s_ov);
    check_value({tag, "_sat_no"}, bus_no.cnt_sat, s_no);
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      check_value("outp_ov", bus_ov.outp, exp_e[1]);
      check_value("outp_no", bus_no.outp, exp_e[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       bits[7];
    logic       e_ov[7];
    logic       e_no[7];
    logic       blk[4];
    int unsigned cnt;

    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    e_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    e_no = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    blk  = '{1'b1, 1'b0, 1'b1, 1'b1};

    reset_n = 1'b0;
    set_inputs(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #3;
    check_value("rst_outp_ov", bus_ov.outp, 0);
    check_value("rst_state_ov", bus_ov.state, 0);
    check_value("rst_state_no", bus_no.state, 0);
    check_counts("rst", 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    for (int i = 0; i < 4; i++) sample(bits[i], e_ov[i], e_no[i]);
    settle();
    check_value("armed_state_ov", bus_ov.state, 2);
    check_value("refill_state_no", bus_no.state, 1);
    for (int i = 4; i < 7; i++) sample(bits[i], e_ov[i], e_no[i]);
    idle();
    settle();
    check_counts("stream", 2, 1, 0, 0);

    // Load 0110 with a live sample in the load cycle
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check_value("load_state_ov", bus_ov.state, 1);
    sample(1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    sample(1'b0, 1'b1, 1'b1);
    idle();
    settle();
    check_counts("load", 3, 2, 0, 0);

    // Disable gap in the middle of a match
    drive(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check_value("dis_state_ov", bus_ov.state, 0);
    check_value("dis_state_no", bus_no.state, 0);
    sample(1'b1, 1'b1, 1'b1);
    idle();
    settle();
    check_counts("enable", 4, 3, 0, 0);

    // Asynchronous reset mid-sequence
    sample(1'b1, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_value("arst_outp_ov", bus_ov.outp, 0);
    check_value("arst_state_ov", bus_ov.state, 0);
    check_counts("arst", 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) sample(blk[i], (i == 3), (i == 3));
    idle();
    settle();
    check_counts("post_rst", 1, 1, 0, 0);

    // Saturation: repeated 1011 matches on both detectors every fourth sample
    cnt = 1;
    for (int k = 0; k < 255; k++) begin
      for (int i = 0; i < 4; i++) sample(blk[i], (i == 3), (i == 3));
      settle();
      if (cnt < 255) cnt++;
      check_counts("sat", cnt, cnt, (cnt == 255), (cnt == 255));
    end
    for (int i = 0; i < 3; i++) sample(blk[i], 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check_counts("clr_match", 1, 1, 0, 0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check_counts("clr", 0, 0, 0, 0);

    idle();
    for (int i = 0; i < 5; i++) if (exp_q.size() != 0) settle();
    check_value("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter OVERLAP, default 1: 1 allows overlapping matches; 0 requires a fresh PAT_W samples after each match.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Parameter RESET_PAT, default 4'b1011 (PAT_W bits): pattern register value after reset.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  1 = detector runs; 0 = samples ignored.
REQ-008 load  input  1  1 = capture pattern_in this cycle.
REQ-009 pattern_in  input  PAT_W  new pattern; MSB is compared with the oldest bit.
REQ-010 inp_valid  input  1  qualifies inp for this cycle.
REQ-011 inp  input  1  serial data bit.
REQ-012 clear_cnt  input  1  synchronous clear of match_count and cnt_sat.
REQ-013 outp  output  1  registered one-cycle match pulse.
REQ-014 match_count  output  CNT_W  number of matches, saturating.
REQ-015 cnt_sat  output  1  sticky flag; set when match_count reaches all-ones.
REQ-016 state  output  2  FSM state: IDLE=00, FILL=01, ARMED=10.

Function
REQ-017 A sample SHALL be accepted only in a cycle with enable=1, inp_valid=1 and load=0.
REQ-018 On each accepted sample, the history register SHALL shift left, with inp entering at bit 0.
REQ-019 The fill counter SHALL increment on each accepted sample and saturate at PAT_W.
REQ-020 A match SHALL occur on an accepted sample when fill+1>=PAT_W and {hist[PAT_W-2:0],inp}==pattern.
REQ-021 outp SHALL be 1 for exactly the one cycle following a matching sample, and 0 otherwise.
REQ-022 Latency: the match sample edge SHALL be followed by outp high after one clock.
REQ-023 With OVERLAP=0, a match SHALL reset fill to 0; with OVERLAP=1, fill SHALL stay at PAT_W.
REQ-024 load=1 SHALL capture pattern_in and clear both fill and history; any sample in that cycle is discarded and outp is 0 next cycle.
REQ-025 While enable=0, history, fill and pattern SHALL hold, and outp SHALL be 0.
REQ-026 match_count SHALL increment by 1 per match and hold at all-ones; cnt_sat SHALL set when the count reaches all-ones and stay set until cleared.
REQ-027 clear_cnt=1 SHALL zero match_count and cnt_sat; a simultaneous match SHALL leave match_count=1 instead.
REQ-028 FSM transitions (evaluated after load/fill update):
- any state with enable=0 -> IDLE;
- IDLE with enable=1 -> FILL if fill<PAT_W, else ARMED;
- FILL -> ARMED when fill reaches PAT_W;
- ARMED -> FILL on a match when OVERLAP=0, or on load;
- illegal encoding 11 -> IDLE next cycle, with outp=0.
REQ-029 state SHALL be the registered FSM state.

Reset
REQ-030 While reset_n=0, asynchronously: outp=0, match_count=0, cnt_sat=0, state=IDLE, fill=0, history=0, pattern=RESET_PAT.
REQ-031 Reset asserted mid-sequence SHALL discard the partial match; after release, the first match requires PAT_W new samples.
REQ-032 Reset deassertion SHALL take effect at the next rising clock edge, with no spurious outp pulse.

Verification (PAT_W=4, pattern 1011, CNT_W=8)
REQ-033 OVERLAP=1, stream 1,0,1,1,0,1,1 -> outp pulses after sample 4 and after sample 7; match_count=2.
REQ-034 OVERLAP=0, same stream -> single pulse after sample 4; match_count=1; state returns to FILL after that match.
REQ-035 load with pattern_in=0110 while inp_valid=1 and inp=1 in the same cycle, then stream 0,1,1,0 -> sample in load cycle discarded; one pulse after the 4th sample.
REQ-036 Stream 1,0,1, then enable=0 for 3 cycles, then 1 -> outp 0 while disabled; pulse after the final 1.
REQ-037 Preload 255 matches, then one more match with clear_cnt=0 -> match_count stays 255 and cnt_sat=1; next, clear_cnt together with a match -> match_count=1, cnt_sat=0.
REQ-038 reset_n pulsed low after stream 1,0,1 -> outputs reset immediately without waiting for a clock edge; a following 1 gives no pulse.
